// File: rtl/inv_stim_checker.sv
// Square-wave stimulus and inversion checker for the on-tile analog inverter.
// Define INV_LATENCY_MEAS_EN to add worst-case stim-to-response latency measurement.
module inv_stim_checker #(
    parameter int DIV_W       = 8,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [7:0]       n_cycles_i,
    output logic             stim_out_o,
    input  logic             resp_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] edge_cnt_o,
    output logic [DIV_W-1:0] max_lat_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [DIV_W-1:0] SYNC_MIN = DIV_W'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   resp_s;
    logic                   resp_prev_q;

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] hlast_q, hlast_d;
    logic [DIV_W-1:0] hcnt_q, hcnt_d;
    logic [8:0]       k_q, k_d;
    logic [7:0]       n_q, n_d;
    logic             stim_q, stim_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] edge_q, edge_d;

    logic busy, half_end, last_k, exp_resp, sample_err, resp_edge, start_acc;

    // Reset to 1 so an idle inverter (input 0, output 1) never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= '1;
            resp_prev_q <= 1'b1;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], resp_in_i};
            resp_prev_q <= resp_s;
        end
    end

    assign resp_s     = sync_q[SYNC_STAGES-1];
    assign busy       = (state_q == S_SETTLE) || (state_q == S_RUN);
    assign half_end   = busy && (hcnt_q == hlast_q);
    assign last_k     = (k_q == ({n_q, 1'b0} - 9'd1));
    assign exp_resp   = (state_q == S_SETTLE) ? 1'b1 : ~stim_q;
    assign sample_err = half_end && (resp_s != exp_resp);
    assign resp_edge  = busy && (resp_s != resp_prev_q);
    assign start_acc  = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i;

    always_comb begin
        state_d = state_q;
        hlast_d = hlast_q;
        hcnt_d  = hcnt_q;
        k_d     = k_q;
        n_d     = n_q;
        stim_d  = stim_q;
        err_d   = err_q;
        edge_d  = edge_q;

        if (sample_err && (err_q != '1))
            err_d = err_q + 1'b1;
        if (resp_edge && (edge_q != '1))
            edge_d = edge_q + 1'b1;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    n_d     = n_cycles_i;
                    // Clamp so the synchronized response settles before the sample clock.
                    hlast_d = (div_i > SYNC_MIN) ? div_i : SYNC_MIN;
                    err_d   = '0;
                    edge_d  = '0;
                    hcnt_d  = '0;
                    k_d     = '0;
                    stim_d  = 1'b0;
                    state_d = (n_cycles_i == 8'd0) ? S_DONE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (half_end) begin
                    state_d = S_RUN;
                    hcnt_d  = '0;
                    k_d     = '0;
                    stim_d  = 1'b1;
                end else begin
                    hcnt_d  = hcnt_q + 1'b1;
                end
            end
            default: begin
                if (half_end) begin
                    hcnt_d = '0;
                    if (last_k) begin
                        state_d = S_DONE;
                        stim_d  = 1'b0;
                    end else begin
                        k_d    = k_q + 9'd1;
                        stim_d = ~stim_q;
                    end
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            hlast_q <= '0;
            hcnt_q  <= '0;
            k_q     <= '0;
            n_q     <= '0;
            stim_q  <= 1'b0;
            err_q   <= '0;
            edge_q  <= '0;
        end else begin
            state_q <= state_d;
            hlast_q <= hlast_d;
            hcnt_q  <= hcnt_d;
            k_q     <= k_d;
            n_q     <= n_d;
            stim_q  <= stim_d;
            err_q   <= err_d;
            edge_q  <= edge_d;
        end
    end

`ifdef INV_LATENCY_MEAS_EN
    // hcnt restarts at every RUN toggle, so its value at the first synced edge is the latency.
    logic             lat_seen_q, lat_seen_d;
    logic [DIV_W-1:0] max_lat_q, max_lat_d;
    logic             lat_hit;

    assign lat_hit = (state_q == S_RUN) && !lat_seen_q && (resp_edge || half_end);

    always_comb begin
        lat_seen_d = lat_seen_q;
        max_lat_d  = max_lat_q;
        if (lat_hit && (hcnt_q > max_lat_q))
            max_lat_d = hcnt_q;
        if (half_end || start_acc)
            lat_seen_d = 1'b0;
        else if (lat_hit)
            lat_seen_d = 1'b1;
        if (start_acc)
            max_lat_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_seen_q <= 1'b0;
            max_lat_q  <= '0;
        end else begin
            lat_seen_q <= lat_seen_d;
            max_lat_q  <= max_lat_d;
        end
    end

    assign max_lat_o = max_lat_q;
`else
    assign max_lat_o = '0;
`endif

    assign stim_out_o = stim_q;
    assign busy_o     = busy;
    assign done_o     = (state_q == S_DONE);
    assign pass_o     = (state_q == S_DONE) && (err_q == '0) && (edge_q == CNT_W'({n_q, 1'b0}));
    assign err_cnt_o  = err_q;
    assign edge_cnt_o = edge_q;

endmodule

// File: tb/tb_inv_stim_checker.sv
// Scoreboard bench for inv_stim_checker with a selectable inverter model
// (ideal, stuck-at-0, stuck-at-1, 3-clock delay).
module tb_inv_stim_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  div = 8'd0;
    logic [7:0]  ncyc = 8'd0;
    logic        stim, resp;
    logic        busy, done, pass;
    logic [15:0] err, edgec;
    logic [7:0]  maxlat;

`ifdef INV_LATENCY_MEAS_EN
    localparam bit LAT = 1'b1;
`else
    localparam bit LAT = 1'b0;
`endif

    inv_stim_checker #(.DIV_W(8), .CNT_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .start_i(start), .div_i(div), .n_cycles_i(ncyc),
        .stim_out_o(stim), .resp_in_i(resp), .busy_o(busy), .done_o(done),
        .pass_o(pass), .err_cnt_o(err), .edge_cnt_o(edgec), .max_lat_o(maxlat)
    );

    always #5 clk = ~clk;

    // Inverter models: 0 ideal, 1 stuck-at-0, 2 stuck-at-1, 3 pure 3-clock delay
    int         mode = 0;
    logic [2:0] dpipe = 3'b111;
    always @(posedge clk) dpipe <= {dpipe[1:0], ~stim};
    always_comb begin
        case (mode)
            0:       resp = ~stim;
            1:       resp = 1'b0;
            2:       resp = 1'b1;
            default: resp = dpipe[2];
        endcase
    end

    typedef struct {
        int busy_len;
        int err;
        int edg;
        bit pass;
        int lat;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int errors = 0;
    bit stim_tr[0:4095];
    int blen;

    // Start a run and record stim_out for every busy cycle; optional stray start at cycle 'poke'.
    task automatic run(input int d, input int n, input int poke);
        @(negedge clk);
        div = 8'(d); ncyc = 8'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        blen = 0;
        while (busy && blen < 4000) begin
            stim_tr[blen] = stim;
            start = (blen == poke);
            blen++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    function automatic int stim_bad(input int d);
        int hh = ((d > 2) ? d : 2) + 1;
        int bad = 0;
        for (int i = 0; i < blen; i++) begin
            int  half = i / hh;
            bit  e = (half >= 1) && (((half - 1) % 2) == 0);
            if (stim_tr[i] !== e) bad++;
        end
        return bad;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(3);
        checks++; if (stim !== 1'b0)    begin errors++; $display("FAIL reset_stim got %b want 0", stim); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (pass !== 1'b0)    begin errors++; $display("FAIL reset_pass got %b want 0", pass); end
        checks++; if (err !== 16'd0)    begin errors++; $display("FAIL reset_err got %0d want 0", err); end
        checks++; if (edgec !== 16'd0)  begin errors++; $display("FAIL reset_edge got %0d want 0", edgec); end
        checks++; if (maxlat !== 8'd0)  begin errors++; $display("FAIL reset_maxlat got %0d want 0", maxlat); end
        rst = 1'b0;
        idle(3);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_state got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_ideal;
        exp_t e;
        mode = 0; idle(4);
        sbq.push_back('{busy_len: 36, err: 0, edg: 8, pass: 1'b1, lat: LAT ? 2 : 0});
        run(3, 4, -1);
        e = sbq.pop_front();
        checks++; if (blen != e.busy_len) begin errors++; $display("FAIL ideal_busy_len got %0d want %0d", blen, e.busy_len); end
        checks++; if (done !== 1'b1)      begin errors++; $display("FAIL ideal_done got %b want 1", done); end
        checks++; if (err !== 16'(e.err)) begin errors++; $display("FAIL ideal_err got %0d want %0d", err, e.err); end
        checks++; if (edgec !== 16'(e.edg)) begin errors++; $display("FAIL ideal_edge got %0d want %0d", edgec, e.edg); end
        checks++; if (pass !== e.pass)    begin errors++; $display("FAIL ideal_pass got %b want %b", pass, e.pass); end
        checks++; if (maxlat !== 8'(e.lat)) begin errors++; $display("FAIL ideal_maxlat got %0d want %0d", maxlat, e.lat); end
        checks++; if (stim_bad(3) != 0)   begin errors++; $display("FAIL ideal_stim_pattern got %0d bad cycles want 0", stim_bad(3)); end
        checks++; if (stim !== 1'b0)      begin errors++; $display("FAIL ideal_stim_done got %b want 0", stim); end
    endtask

    task automatic test_stuck(input bit lvl);
        exp_t e;
        mode = lvl ? 2 : 1; idle(5);
        sbq.push_back('{busy_len: 36, err: lvl ? 4 : 5, edg: 0, pass: 1'b0, lat: LAT ? 3 : 0});
        run(3, 4, -1);
        e = sbq.pop_front();
        checks++; if (blen != e.busy_len) begin errors++; $display("FAIL stuck%0d_busy_len got %0d want %0d", lvl, blen, e.busy_len); end
        checks++; if (err !== 16'(e.err)) begin errors++; $display("FAIL stuck%0d_err got %0d want %0d", lvl, err, e.err); end
        checks++; if (edgec !== 16'(e.edg)) begin errors++; $display("FAIL stuck%0d_edge got %0d want %0d", lvl, edgec, e.edg); end
        checks++; if (pass !== e.pass || done !== 1'b1) begin errors++; $display("FAIL stuck%0d_pass got pass=%b done=%b want %b 1", lvl, pass, done, e.pass); end
        checks++; if (maxlat !== 8'(e.lat)) begin errors++; $display("FAIL stuck%0d_maxlat got %0d want %0d", lvl, maxlat, e.lat); end
    endtask

    task automatic test_div_clamp;
        exp_t e;
        mode = 0; idle(5);
        sbq.push_back('{busy_len: 15, err: 0, edg: 4, pass: 1'b1, lat: LAT ? 2 : 0});
        run(0, 2, -1);
        e = sbq.pop_front();
        checks++; if (blen != e.busy_len) begin errors++; $display("FAIL clamp_busy_len got %0d want %0d", blen, e.busy_len); end
        checks++; if (stim_bad(0) != 0)   begin errors++; $display("FAIL clamp_stim_pattern got %0d bad cycles want 0", stim_bad(0)); end
        checks++; if (err !== 16'(e.err) || edgec !== 16'(e.edg)) begin errors++; $display("FAIL clamp_counts got err=%0d edge=%0d want %0d %0d", err, edgec, e.err, e.edg); end
        checks++; if (pass !== e.pass)    begin errors++; $display("FAIL clamp_pass got %b want %b", pass, e.pass); end
    endtask

    task automatic test_zero_cycles;
        exp_t e;
        mode = 0;
        sbq.push_back('{busy_len: 0, err: 0, edg: 0, pass: 1'b1, lat: 0});
        run(3, 0, -1);
        e = sbq.pop_front();
        checks++; if (blen != e.busy_len) begin errors++; $display("FAIL zero_busy_len got %0d want %0d", blen, e.busy_len); end
        checks++; if (done !== 1'b1 || pass !== e.pass) begin errors++; $display("FAIL zero_done_pass got done=%b pass=%b want 1 1", done, pass); end
        checks++; if (err !== 16'd0 || edgec !== 16'd0 || maxlat !== 8'd0) begin errors++; $display("FAIL zero_counters got err=%0d edge=%0d lat=%0d want 0 0 0", err, edgec, maxlat); end
        checks++; if (stim !== 1'b0)      begin errors++; $display("FAIL zero_stim got %b want 0", stim); end
    endtask

    task automatic test_reset_midrun;
        exp_t e;
        mode = 0;
        @(negedge clk); div = 8'd3; ncyc = 8'd4; start = 1'b1;
        @(negedge clk); start = 1'b0;
        idle(10);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy got %b want 1", busy); end
        rst = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; rst = 1'b0;
        checks++; if ({stim, busy, done, pass} !== 4'b0000) begin errors++; $display("FAIL midrun_reset_flags got %b want 0000", {stim, busy, done, pass}); end
        checks++; if (err !== 16'd0 || edgec !== 16'd0 || maxlat !== 8'd0) begin errors++; $display("FAIL midrun_reset_counts got err=%0d edge=%0d lat=%0d want 0", err, edgec, maxlat); end
        idle(1);
        sbq.push_back('{busy_len: 20, err: 0, edg: 4, pass: 1'b1, lat: LAT ? 2 : 0});
        run(3, 2, -1);
        e = sbq.pop_front();
        checks++; if (blen != e.busy_len) begin errors++; $display("FAIL after_reset_busy_len got %0d want %0d", blen, e.busy_len); end
        checks++; if (pass !== e.pass || edgec !== 16'(e.edg)) begin errors++; $display("FAIL after_reset_result got pass=%b edge=%0d want %b %0d", pass, edgec, e.pass, e.edg); end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        mode = 0;
        // Stray start mid-run is ignored; restart directly from DONE clears counters.
        sbq.push_back('{busy_len: 20, err: 0, edg: 4, pass: 1'b1, lat: LAT ? 2 : 0});
        run(3, 2, 7);
        e = sbq.pop_front();
        checks++; if (blen != e.busy_len) begin errors++; $display("FAIL b2b_busy_len got %0d want %0d", blen, e.busy_len); end
        checks++; if (edgec !== 16'(e.edg) || pass !== e.pass) begin errors++; $display("FAIL b2b_result got edge=%0d pass=%b want %0d %b", edgec, pass, e.edg, e.pass); end
    endtask

    task automatic test_latency;
        exp_t e;
        mode = 3; idle(6);
        sbq.push_back('{busy_len: 70, err: 0, edg: 6, pass: 1'b1, lat: LAT ? 5 : 0});
        run(9, 3, -1);
        e = sbq.pop_front();
        checks++; if (blen != e.busy_len) begin errors++; $display("FAIL lat_busy_len got %0d want %0d", blen, e.busy_len); end
        checks++; if (err !== 16'(e.err) || edgec !== 16'(e.edg)) begin errors++; $display("FAIL lat_counts got err=%0d edge=%0d want %0d %0d", err, edgec, e.err, e.edg); end
        checks++; if (pass !== e.pass)    begin errors++; $display("FAIL lat_pass got %b want %b", pass, e.pass); end
        checks++; if (maxlat !== 8'(e.lat)) begin errors++; $display("FAIL lat_maxlat got %0d want %0d", maxlat, e.lat); end
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_stuck(1'b0);
        test_stuck(1'b1);
        test_div_clamp();
        test_zero_cycles();
        test_reset_midrun();
        test_back_to_back();
        test_latency();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
